pll_seq_ctrl: RTL
=================

PLL_SEQ_CTRL -- requirements
Module: pll_seq_ctrl

Interface
REQ-001 SHALL have parameter RST_CYC, default 4: cycles the PLL is held in reset per attempt.
REQ-002 SHALL have parameter SETTLE_CYC, default 64: cycles after reset release during which lock is ignored.
REQ-003 SHALL have parameter LOCK_CYC, default 16: consecutive synchronized lock-high cycles required to declare lock.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024: WAIT_LOCK cycles allowed per attempt.
REQ-005 SHALL have parameter MAX_RETRY, default 3, range 0..7: retries allowed after the first attempt.
REQ-006 SHALL have parameter LOL_FILT, default 2: consecutive synchronized lock-low cycles in LOCKED that declare loss of lock.
REQ-007 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: level run request; 1 means sequence and hold the PLL, 0 means shut it down.
REQ-010 SHALL have port lock_raw, input, 1 bit: asynchronous PLL lock indicator.
REQ-011 SHALL have port pll_rst_n, output, 1 bit: active-low reset to the PLL.
REQ-012 SHALL have port pll_enable, output, 1 bit: enable to the PLL.
REQ-013 SHALL have port locked, output, 1 bit: qualified lock status.
REQ-014 SHALL have port busy, output, 1 bit: high in RESET, SETTLE and WAIT_LOCK.
REQ-015 SHALL have port fail, output, 1 bit: retries exhausted.
REQ-016 SHALL have port lol, output, 1 bit: one-cycle loss-of-lock pulse.
REQ-017 SHALL have port retry_cnt, output, 3 bits: retries consumed in the current run.
REQ-018 SHALL have port state, output, 3 bits: encoded FSM state.

Function
REQ-019 SHALL pass lock_raw through a 2-flop synchronizer to produce lock_s, with 2-cycle latency; only lock_s is used internally.
REQ-020 SHALL implement the states IDLE=0, RESET=1, SETTLE=2, WAIT_LOCK=3, LOCKED=4, FAIL=5; codes 6 and 7 SHALL return to IDLE.
REQ-021 SHALL use one shared timer, cleared on every state entry and incremented every cycle in that state.
REQ-022 IDLE: pll_rst_n=0, pll_enable=0; start=1 SHALL go to RESET.
REQ-023 RESET: pll_rst_n=0, pll_enable=0; after exactly RST_CYC cycles SHALL go to SETTLE.
REQ-024 SETTLE: pll_rst_n=1, pll_enable=1, lock_s ignored; after exactly SETTLE_CYC cycles SHALL go to WAIT_LOCK.
REQ-025 WAIT_LOCK lock qualification: pll_rst_n=1, pll_enable=1; the lock-run counter increments while lock_s=1 and clears when lock_s=0; reaching LOCK_CYC SHALL go to LOCKED.
REQ-026 WAIT_LOCK timeout: after TIMEOUT_CYC cycles, if retry_cnt<MAX_RETRY SHALL increment retry_cnt and go to RESET; otherwise SHALL go to FAIL.
REQ-027 WAIT_LOCK tie-break: when lock qualification and timeout occur in the same cycle, lock SHALL win.
REQ-028 LOCKED: locked=1, PLL enabled; LOL_FILT consecutive lock_s=0 cycles SHALL pulse lol for 1 cycle, clear retry_cnt and go to RESET; shorter dips SHALL be ignored.
REQ-029 FAIL: fail=1, pll_rst_n=0, pll_enable=0; SHALL hold until start=0, then go to IDLE.
REQ-030 start=0 in any non-IDLE state SHALL force IDLE on the next edge and clear retry_cnt; this has priority over all other transitions except rst.
REQ-031 All outputs SHALL be registered and decoded from the next state, so outputs change on the same edge as the state.

Reset
REQ-032 rst=1 SHALL, on the next edge and overriding everything, set state=IDLE, pll_rst_n=0, pll_enable=0, locked=0, busy=0, fail=0, lol=0, retry_cnt=0, clear the timer, lock-run and LOL counters, and clear the synchronizer flops.
REQ-033 rst asserted mid-operation, including in LOCKED, SHALL behave identically to REQ-032; no state is retained.

Structure
REQ-034 SHALL place the state encoding enum and a timer-width constant (clog2 of the largest cycle parameter, plus 1) in the shared package pll_pkg.
REQ-035 SHALL instantiate exactly one sub-module, sync_2ff, for lock_raw; the FSM and counters stay in pll_seq_ctrl.

Verification (default parameters)
REQ-036 rst released, start=1, lock_raw=1 constant -> busy=1 immediately; pll_rst_n rises 4 cycles after RESET entry; locked=1 exactly 84 cycles after RESET entry (4+64+16); retry_cnt=0.
REQ-037 start=1, lock_raw=0 constant -> retry_cnt steps 1,2,3 at each timeout; after the 4th timeout fail=1, pll_enable=0, pll_rst_n=0, busy=0; fail holds while start=1.
REQ-038 lock_raw drops low for 1 cycle after 10 lock-high cycles in WAIT_LOCK -> lock-run counter restarts; locked rises 16 lock-high cycles after the dip, not earlier.
REQ-039 In LOCKED: lock_raw low for 1 cycle -> no change. Low for 3 cycles -> a single lol pulse, locked=0, state=RESET, retry_cnt=0, and a full re-sequence to locked.
REQ-040 start=0 mid-SETTLE -> state=IDLE, pll_enable=0, pll_rst_n=0 on the next edge. rst=1 in LOCKED -> all REQ-032 values on the next edge.
REQ-041 From FAIL, start=0 for 1 cycle then start=1 -> IDLE then RESET, with retry_cnt=0 and a fresh sequence.

Source files
------------

// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared state encoding and timer sizing for the PLL sequencer
//
// Purpose: state enum for pll_seq_ctrl and the helper that sizes its shared
// timer (clog2 of the largest cycle count, plus one bit of headroom).
// Ports: none (package).
package pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_e;

  function automatic int tmr_width(input int rst_cyc, input int settle_cyc,
                                   input int timeout_cyc);
    int m;
    m = rst_cyc;
    if (settle_cyc > m) m = settle_cyc;
    if (timeout_cyc > m) m = timeout_cyc;
    return $clog2(m) + 1;
  endfunction

  // Width for the default parameter set; instances with larger counts widen it.
  localparam int TMR_W = tmr_width(4, 64, 1024);

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
//
// Purpose: bring an asynchronous level into the clk domain with 2-cycle latency.
// Ports:
//   clk - sampling clock
//   rst - synchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_seq_ctrl.sv
// rtl/pll_seq_ctrl.sv - PLL power-up / lock qualification / retry sequencer
//
// Purpose: holds the PLL in reset, releases it, waits out settling, qualifies
// lock, retries on timeout and re-sequences on loss of lock.
// Ports:
//   clk_in     - clock, all logic on rising edge
//   rst        - synchronous active-high reset
//   start      - level run request (0 shuts the PLL down)
//   lock_raw   - asynchronous PLL lock indicator
//   pll_rst_n  - active-low reset to the PLL
//   pll_enable - PLL enable
//   locked     - qualified lock status
//   busy       - high while sequencing (RESET, SETTLE, WAIT_LOCK)
//   fail       - retries exhausted
//   lol        - one-cycle loss-of-lock pulse
//   retry_cnt  - retries consumed in the current run
//   state      - encoded FSM state
module pll_seq_ctrl
  import pll_pkg::*;
#(
  parameter int RST_CYC     = 4,
  parameter int SETTLE_CYC  = 64,
  parameter int LOCK_CYC    = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 3,
  parameter int LOL_FILT    = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic       lock_raw,
  output logic       pll_rst_n,
  output logic       pll_enable,
  output logic       locked,
  output logic       busy,
  output logic       fail,
  output logic       lol,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  localparam int TW_CALC = tmr_width(RST_CYC, SETTLE_CYC, TIMEOUT_CYC);
  localparam int TW      = (TW_CALC > TMR_W) ? TW_CALC : TMR_W;
  localparam int RUN_W   = $clog2(LOCK_CYC) + 1;
  localparam int LOL_W   = $clog2(LOL_FILT) + 1;

  logic lock_s;

  sync_2ff u_sync (
    .clk (clk_in),
    .rst (rst),
    .d   (lock_raw),
    .q   (lock_s)
  );

  pll_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [LOL_W-1:0] lolc_q, lolc_d;
  logic [2:0]       retry_q, retry_d;
  logic             lol_evt;
  logic             seq_state;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      run_q      <= '0;
      lolc_q     <= '0;
      retry_q    <= '0;
      pll_rst_n  <= 1'b0;
      pll_enable <= 1'b0;
      locked     <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
      lol        <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      run_q      <= run_d;
      lolc_q     <= lolc_d;
      retry_q    <= retry_d;
      // Outputs are decoded from the next state so they move with the state.
      pll_rst_n  <= (state_d == ST_SETTLE) || (state_d == ST_WAIT_LOCK) ||
                    (state_d == ST_LOCKED);
      pll_enable <= (state_d == ST_SETTLE) || (state_d == ST_WAIT_LOCK) ||
                    (state_d == ST_LOCKED);
      locked     <= (state_d == ST_LOCKED);
      busy       <= (state_d == ST_RESET) || (state_d == ST_SETTLE) ||
                    (state_d == ST_WAIT_LOCK);
      fail       <= (state_d == ST_FAIL);
      lol        <= lol_evt;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    run_d     = run_q;
    lolc_d    = lolc_q;
    retry_d   = retry_q;
    lol_evt   = 1'b0;
    seq_state = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RESET;
      end
      ST_RESET: begin
        seq_state = 1'b1;
        if (timer_q == TW'(RST_CYC - 1)) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        seq_state = 1'b1;
        if (timer_q == TW'(SETTLE_CYC - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        seq_state = 1'b1;
        run_d     = lock_s ? run_q + RUN_W'(1) : '0;
        // Lock qualification is tested first so it wins a same-cycle timeout.
        if (lock_s && (run_q == RUN_W'(LOCK_CYC - 1))) begin
          state_d = ST_LOCKED;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          if (retry_q < 3'(MAX_RETRY)) begin
            retry_d = retry_q + 3'd1;
            state_d = ST_RESET;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_LOCKED: begin
        lolc_d = lock_s ? '0 : lolc_q + LOL_W'(1);
        if (!lock_s && (lolc_q == LOL_W'(LOL_FILT - 1))) begin
          state_d = ST_RESET;
          retry_d = '0;
          lol_evt = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping start shuts everything down regardless of where we are.
    if (!start && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      retry_d = '0;
      lol_evt = 1'b0;
    end

    // One timer shared by all states: zero on entry, count while sequencing.
    if (state_d != state_q) begin
      timer_d = '0;
      run_d   = '0;
      lolc_d  = '0;
    end else if (seq_state) begin
      timer_d = timer_q + TW'(1);
    end
  end

  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
